// File: rtl/rng_arbiter_if.sv
// Bundle of request/seed/response signals between game-logic requesters
// and the shared random-number arbiter.
interface rng_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic             seed_we;
  logic [9:0]       seed;
  logic [N_REQ-1:0] ack;
  logic [9:0]       rnd_value;
  logic [2:0]       grant_id;
  logic             busy;

  // Requester / host side
  modport master (
    output req, seed_we, seed,
    input  ack, rnd_value, grant_id, busy
  );

  // Arbiter side
  modport slave (
    input  req, seed_we, seed,
    output ack, rnd_value, grant_id, busy
  );
endinterface

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 10-bit Fibonacci LFSR between N_REQ
// requesters. Each grant runs the LFSR STEPS times so the delivered value
// is fully refreshed, then pulses a one-hot ack for one cycle.
module rng_arbiter #(
  parameter int         N_REQ = 4,
  parameter int         STEPS = 10,
  parameter logic [9:0] SEED  = 10'h00F
) (
  input logic         clk,
  input logic         reset,
  rng_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [9:0]       lfsr_reg, lfsr_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] last_reg, last_next;
  logic [N_REQ-1:0] ack_reg, ack_next;
  logic [9:0]       rnd_reg, rnd_next;

  // Candidate requester indices in priority order: offset 0 is last+1.
  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((32'(last_reg) + gi + 1) % N_REQ);
    end
  endgenerate

  // Round-robin pick: scan from the lowest-priority offset down so the
  // nearest set request after the last grant wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_reg;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[cand_idx[i]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

  // Next-state and datapath decode for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    ack_next   = '0;
    rnd_next   = rnd_reg;
    case (state_reg)
      IDLE: begin
        if (bus.seed_we) begin
          // A zero seed would lock the LFSR, so substitute the default.
          lfsr_next = (bus.seed == 10'd0) ? SEED : bus.seed;
        end else if (pick_valid) begin
          grant_next = pick_idx;
          cnt_next   = 4'd0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_next = {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
        cnt_next  = cnt_reg + 4'd1;
        if (cnt_reg == 4'(STEPS - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        rnd_next             = lfsr_reg;
        ack_next[grant_reg]  = 1'b1;
        last_next            = grant_reg;
        state_next           = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      lfsr_reg  <= SEED;
      cnt_reg   <= 4'd0;
      grant_reg <= '0;
      last_reg  <= IDX_W'(N_REQ - 1);
      ack_reg   <= '0;
      rnd_reg   <= 10'd0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      ack_reg   <= ack_next;
      rnd_reg   <= rnd_next;
    end
  end

  assign bus.ack       = ack_reg;
  assign bus.rnd_value = rnd_reg;
  assign bus.grant_id  = 3'(grant_reg);
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed self-checking bench for rng_arbiter: latency, round-robin order,
// reseeding rules, mid-operation reset and dropped requests.
module tb_rng_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [9:0] model_lfsr;
  logic [9:0] exp_val;
  int   ack_seen;

  rng_arbiter_if #(.N_REQ(4)) bus ();

  rng_arbiter #(.N_REQ(4), .STEPS(10), .SEED(10'h00F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: n shifts of x^10 + x^7 Fibonacci taps.
  function automatic logic [9:0] lfsr_steps(input logic [9:0] v, input int n);
    logic [9:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[8:0], r[9] ^ r[6]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.req     = '0;
    bus.seed_we = 1'b0;
    bus.seed    = '0;
    tick();
    tick();
    reset      = 1'b0;
    model_lfsr = 10'h00F;
  endtask

  // Wait for one ack and check it. req_hold: 0 = drop req on ack,
  // >0 = drop req after that many ticks, <0 = keep req. seed_at: tick
  // after which a one-cycle seed_we pulse is driven (any pending strobe
  // is cleared after the first tick).
  task automatic wait_ack(input string tag, input logic [3:0] exp_ack,
                          input logic [9:0] exp_rnd, input int exp_gid,
                          input int exp_lat, input int req_hold,
                          input int seed_at, input logic [9:0] seed_val);
    int t;
    int busy_n;
    bit seen;
    t = 0;
    busy_n = 0;
    seen = 0;
    while (!seen && t < 60) begin
      tick();
      t++;
      if (bus.busy) busy_n++;
      bus.seed_we = (t == seed_at);
      if (t == seed_at) bus.seed = seed_val;
      if (req_hold > 0 && t == req_hold) bus.req = '0;
      if (bus.ack != '0) begin
        seen = 1;
        $display("txn %s: ack=%b rnd=0x%03h gid=%0d latency=%0d busy=%0d",
                 tag, bus.ack, bus.rnd_value, bus.grant_id, t, busy_n);
        check({tag, "_ack"}, 32'(bus.ack), 32'(exp_ack));
        check({tag, "_rnd"}, 32'(bus.rnd_value), 32'(exp_rnd));
        check({tag, "_gid"}, 32'(bus.grant_id), 32'(exp_gid));
        check({tag, "_lat"}, 32'(t), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_n), 32'd11);
        if (req_hold == 0) bus.req = '0;
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_acks(input int n);
    ack_seen = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.ack != '0) ack_seen++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.seed_we = 1'b0;
    bus.seed = '0;

    // 1: reset values, single request
    do_reset();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rnd", 32'(bus.rnd_value), 32'd0);
    check("rst_gid", 32'(bus.grant_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0001;
    wait_ack("t1", 4'b0001, 10'h077, 0, 12, 0, 0, 10'h0);
    tick();
    check("t1_ack_pulse", 32'(bus.ack), 32'd0);
    check("t1_idle", 32'(bus.busy), 32'd0);

    // 2: all requesting, round-robin order and chained values
    do_reset();
    bus.req = 4'b1111;
    exp_val = 10'h077;
    wait_ack("t2a", 4'b0001, exp_val, 0, 12, -1, 0, 10'h0);
    exp_val = lfsr_steps(exp_val, 10);
    wait_ack("t2b", 4'b0010, exp_val, 1, 12, -1, 0, 10'h0);
    exp_val = lfsr_steps(exp_val, 10);
    wait_ack("t2c", 4'b0100, exp_val, 2, 12, -1, 0, 10'h0);
    exp_val = lfsr_steps(exp_val, 10);
    wait_ack("t2d", 4'b1000, exp_val, 3, 12, -1, 0, 10'h0);
    exp_val = lfsr_steps(exp_val, 10);
    wait_ack("t2e", 4'b0001, exp_val, 0, 12, 0, 0, 10'h0);
    model_lfsr = exp_val;

    // 3: zero seed falls back to default, then a full-ones seed
    bus.seed_we = 1'b1;
    bus.seed = 10'h000;
    tick();
    bus.seed_we = 1'b0;
    bus.req = 4'b0100;
    wait_ack("t3a", 4'b0100, 10'h077, 2, 12, 0, 0, 10'h0);
    bus.seed_we = 1'b1;
    bus.seed = 10'h3FF;
    tick();
    bus.seed_we = 1'b0;
    bus.req = 4'b0100;
    model_lfsr = lfsr_steps(10'h3FF, 10);
    wait_ack("t3b", 4'b0100, model_lfsr, 2, 12, 0, 0, 10'h0);

    // 4a: reseed during SHIFT is ignored
    bus.req = 4'b0010;
    model_lfsr = lfsr_steps(model_lfsr, 10);
    wait_ack("t4a", 4'b0010, model_lfsr, 1, 12, 0, 3, 10'h155);
    // 4b: reseed and request together: reseed first, grant one cycle later
    bus.seed_we = 1'b1;
    bus.seed = 10'h2AA;
    bus.req = 4'b0001;
    model_lfsr = lfsr_steps(10'h2AA, 10);
    wait_ack("t4b", 4'b0001, model_lfsr, 0, 13, 0, 0, 10'h0);

    // 5: reset in the middle of SHIFT aborts the grant
    bus.req = 4'b0001;
    for (int k = 0; k < 5; k++) tick();
    check("t5_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = '0;
    check("t5_busy_after", 32'(bus.busy), 32'd0);
    check("t5_ack_after", 32'(bus.ack), 32'd0);
    count_acks(20);
    check("t5_no_ack", 32'(ack_seen), 32'd0);
    bus.req = 4'b0001;
    wait_ack("t5", 4'b0001, 10'h077, 0, 12, 0, 0, 10'h0);
    model_lfsr = 10'h077;

    // 6: one-cycle request still completes, pointer advances past it
    bus.req = 4'b0010;
    model_lfsr = lfsr_steps(model_lfsr, 10);
    wait_ack("t6a", 4'b0010, model_lfsr, 1, 12, 1, 0, 10'h0);
    count_acks(15);
    check("t6_no_regrant", 32'(ack_seen), 32'd0);
    bus.req = 4'b0110;
    model_lfsr = lfsr_steps(model_lfsr, 10);
    wait_ack("t6b", 4'b0100, model_lfsr, 2, 12, 0, 0, 10'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
